bus_term: RTL and testbench

BUS_TERM -- requirements
Module: bus_term

---
 rtl/bus_term.sv | 135 +++++++++++++
 tb/tb_bus_term.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_term.sv
// bus_term: 68020-side bus terminator that turns a synchronised 68000 DTACK into DSACK1.
// Optional watchdog timeout (WAIT -> ERR, BERR) is built when BUS_TERM_TIMEOUT_EN is defined.
module bus_term #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic CLKCPU,
  input  logic RESET,
  input  logic AS20,
  input  logic DTACK_DLY,
  output logic DSACK1,
  output logic BERR,
  output logic BUSY
);

  if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_timeout_range
    $error("bus_term: TIMEOUT must lie in 4..255");
  end

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWait    = 3'd1,
    StAck     = 3'd2,
`ifdef BUS_TERM_TIMEOUT_EN
    StErr     = 3'd3,
`endif
    StRecover = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Two-flop synchroniser for the asynchronous upstream DTACK.
  logic dt_meta_q;
  logic dt_s_q;

  logic dsack1_q;
  logic busy_q;

`ifdef BUS_TERM_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       berr_q;
`endif

  always_comb begin
    state_d = state_q;
`ifdef BUS_TERM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (!AS20) begin
          state_d = StWait;
`ifdef BUS_TERM_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      StWait: begin
        // Abort wins, then termination, then timeout, so a late DTACK beats BERR.
        if (AS20) begin
          state_d = StIdle;
        end else if (!dt_s_q) begin
          state_d = StAck;
`ifdef BUS_TERM_TIMEOUT_EN
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StErr;
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StAck: begin
        if (AS20) begin
          state_d = StRecover;
        end
      end
`ifdef BUS_TERM_TIMEOUT_EN
      StErr: begin
        if (AS20) begin
          state_d = StRecover;
        end
      end
`endif
      StRecover: begin
        // Wait for the stale DTACK to clear; a strobe already pending starts a new cycle.
        if (dt_s_q) begin
          state_d = AS20 ? StIdle : StWait;
`ifdef BUS_TERM_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q   <= StIdle;
      dt_meta_q <= 1'b1;
      dt_s_q    <= 1'b1;
      dsack1_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dt_meta_q <= DTACK_DLY;
      dt_s_q    <= dt_meta_q;
      dsack1_q  <= (state_d != StAck);
      busy_q    <= (state_d != StIdle);
    end
  end

`ifdef BUS_TERM_TIMEOUT_EN
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      cnt_q  <= 8'd0;
      berr_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= (state_d != StErr);
    end
  end

  assign BERR = berr_q;
`else
  assign BERR = 1'b1;
`endif

  assign DSACK1 = dsack1_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_bus_term.sv
// tb_bus_term: vector table, hand-built corner sequences and randomized run against
// a cycle-level behavioural model of bus_term (TIMEOUT = 20).
module tb_bus_term;

  localparam int unsigned To = 20;
`ifdef BUS_TERM_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic as_n = 1'b1;
  logic dt_n = 1'b1;
  logic ds, be, busy;

  always #5 clk = ~clk;

  bus_term #(.TIMEOUT(To)) dut (
    .CLKCPU   (clk),
    .RESET    (rst),
    .AS20     (as_n),
    .DTACK_DLY(dt_n),
    .DSACK1   (ds),
    .BERR     (be),
    .BUSY     (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int idx, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b, expected %b (t=%0t)", name, idx, got, exp, $time);
    end
  endtask

  // Behavioural model: a bus cycle is either waiting, terminated (ack/err) or draining
  // the stale DTACK; DT_S is simply the DTACK value sampled two edges earlier.
  bit m_active, m_drain;
  int m_term;       // 0 none, 1 acknowledged, 2 bus error
  int m_wait;
  bit m_hist[$];

  function automatic void model_reset();
    m_active = 0; m_drain = 0; m_term = 0; m_wait = 0;
    m_hist = '{1'b1, 1'b1};
  endfunction

  function automatic void model_step(bit r, bit a, bit d);
    bit dts;
    if (!r) begin
      model_reset();
      return;
    end
    dts = m_hist[0];
    if (m_drain) begin
      if (dts) begin
        m_drain = 0;
        if (!a) begin m_active = 1; m_wait = 0; end
      end
    end else if (m_term != 0) begin
      if (a) begin m_term = 0; m_drain = 1; end
    end else if (m_active) begin
      if (a) m_active = 0;
      else if (!dts) begin m_active = 0; m_term = 1; end
      else if (TimeoutEn && m_wait == int'(To)) begin m_active = 0; m_term = 2; end
      else m_wait++;
    end else if (!a) begin
      m_active = 1; m_wait = 0;
    end
    void'(m_hist.pop_front());
    m_hist.push_back(d);
  endfunction

  task automatic step(input logic r, input logic a, input logic d);
    @(negedge clk);
    rst = r; as_n = a; dt_n = d;
    @(posedge clk);
    model_step(r, a, d);
    #1;
  endtask

  task automatic expect3(input string name, input int idx, input logic eds, input logic ebe,
                         input logic ebusy);
    check({name, ".dsack1"}, idx, ds, eds);
    check({name, ".berr"}, idx, be, ebe);
    check({name, ".busy"}, idx, busy, ebusy);
  endtask

  typedef struct {
    logic rst, as_n, dt_n;
    logic ds, be, busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic a, logic d, logic eds, logic ebe, logic ebusy,
                              int reps);
    vec_t v;
    v.rst = r; v.as_n = a; v.dt_n = d; v.ds = eds; v.be = ebe; v.busy = ebusy;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endfunction

  initial begin
    int as_hold, dt_hold;
    logic a, d, r;

    // Reset, then idle with strobe high.
    add(0, 1, 1, 1, 1, 0, 2);
    add(1, 1, 1, 1, 1, 0, 2);
    // Normal cycle: DTACK low before edge 5 -> DSACK1 low after edge 7.
    add(1, 0, 1, 1, 1, 1, 5);
    add(1, 0, 0, 1, 1, 1, 2);
    add(1, 0, 0, 0, 1, 1, 2);
    add(1, 1, 0, 1, 1, 1, 1);
    add(1, 1, 1, 1, 1, 1, 2);
    add(1, 1, 1, 1, 1, 0, 2);
    // Aborted cycle: no termination pulse.
    add(1, 0, 1, 1, 1, 1, 3);
    add(1, 1, 1, 1, 1, 0, 1);
    // Stale DTACK holds RECOVER; a pending strobe goes straight back to WAIT.
    add(1, 0, 0, 1, 1, 1, 2);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 1, 1, 1, 1, 1, 1);
    add(1, 0, 1, 1, 1, 1, 2);
    add(1, 0, 0, 1, 1, 1, 2);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 1, 1, 1, 1, 1, 2);
    add(1, 1, 1, 1, 1, 0, 1);
    // Reset while acknowledged; sync flops must come out of reset high.
    add(1, 0, 0, 1, 1, 1, 2);
    add(1, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 1, 2);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 1, 1, 1, 1, 1, 2);
    add(1, 1, 1, 1, 1, 0, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].as_n, vecs[i].dt_n);
      expect3("vec", i, vecs[i].ds, vecs[i].be, vecs[i].busy);
    end

`ifdef BUS_TERM_TIMEOUT_EN
    // Timeout: BERR low after edge 21, released once strobe goes high.
    for (int k = 0; k <= 23; k++) begin
      step(1, 0, 1);
      expect3("timeout", k, 1'b1, (k < 21) ? 1'b1 : 1'b0, 1'b1);
    end
    step(1, 1, 1);
    expect3("timeout_rel", 0, 1'b1, 1'b1, 1'b1);
    step(1, 1, 1);
    expect3("timeout_rel", 1, 1'b1, 1'b1, 1'b0);
    // DT_S low exactly when counter == TIMEOUT: ACK wins.
    for (int k = 0; k <= 21; k++) begin
      step(1, 0, (k >= 19) ? 1'b0 : 1'b1);
      expect3("race", k, (k < 21) ? 1'b1 : 1'b0, 1'b1, 1'b1);
    end
    step(1, 1, 1);
    expect3("race_rel", 0, 1'b1, 1'b1, 1'b1);
    step(1, 1, 1);
    expect3("race_rel", 1, 1'b1, 1'b1, 1'b1);
    step(1, 1, 1);
    expect3("race_rel", 2, 1'b1, 1'b1, 1'b0);
`else
    // No timeout logic: a 300-cycle stall never raises BERR.
    for (int k = 0; k < 300; k++) begin
      step(1, 0, 1);
      expect3("stall", k, 1'b1, 1'b1, 1'b1);
    end
    step(1, 1, 1);
    expect3("stall_end", 0, 1'b1, 1'b1, 1'b0);
`endif

    // Randomized run against the model.
    step(0, 1, 1);
    step(0, 1, 1);
    a = 1'b1; d = 1'b1; as_hold = 0; dt_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (as_hold == 0) begin a = ~a; as_hold = $urandom_range(1, 30); end
      if (dt_hold == 0) begin d = ~d; dt_hold = $urandom_range(1, 40); end
      as_hold--; dt_hold--;
      r = ($urandom_range(0, 299) != 0);
      step(r, a, d);
      expect3("rand", i, (m_term != 1), (m_term != 2), (m_active || m_drain || m_term != 0));
      check("rand.exclusive", i, ds | be, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
